vga_pixel_gen: RTL and testbench

- Pixel source directly downstream of the VGA timing generator. It consumes the timing generator's hsync, vsync, blank_n, disp_enable and Xpix/Ypix outputs.
- It produces 8-bit R/G/B for the ADV7123 DAC, plus hsync/vsync/blank_n re-aligned to the pixel pipeline delay.
- It renders one of four patterns, selectable at frame boundaries: colour bars, checkerboard, bouncing box, flat grey.

---
 rtl/vga_pkg.sv | 61 ++++++
 rtl/vga_box_motion.sv | 74 +++++++
 rtl/vga_pixel_gen.sv | 140 ++++++++++++++
 tb/tb_vga_pixel_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path: display geometry defaults, colour
// constants, pattern mode encodings and the box-motion direction type.
package vga_pkg;

    localparam int   DEF_H_DISP    = 1280;
    localparam int   DEF_V_DISP    = 1024;
    localparam int   DEF_BOX_SIZE  = 64;
    localparam int   DEF_BOX_STEP  = 4;
    localparam int   DEF_CHK_SHIFT = 5;
    localparam logic DEF_SYNC_ACT  = 1'b0;

    // Coordinates are 11 bits; box arithmetic is widened by one bit to avoid overflow.
    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_w_t;

    typedef logic [23:0] rgb_t;

    localparam rgb_t WHITE   = 24'hFFFFFF;
    localparam rgb_t YELLOW  = 24'hFFFF00;
    localparam rgb_t CYAN    = 24'h00FFFF;
    localparam rgb_t GREEN   = 24'h00FF00;
    localparam rgb_t MAGENTA = 24'hFF00FF;
    localparam rgb_t RED     = 24'hFF0000;
    localparam rgb_t BLUE    = 24'h0000FF;
    localparam rgb_t BLACK   = 24'h000000;
    localparam rgb_t GREY    = 24'h808080;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_BOX   = 2'd2,
        MODE_GREY  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    typedef struct packed {
        dir_e   dir;
        coord_t pos;
    } axis_t;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_box_motion.sv
// Bouncing-box position: each axis is an INC/DEC state machine that steps once
// per frame event and reflects at the edges of the visible area.
module vga_box_motion
    import vga_pkg::*;
#(
    parameter int H_DISP   = DEF_H_DISP,
    parameter int V_DISP   = DEF_V_DISP,
    parameter int BOX_SIZE = DEF_BOX_SIZE,
    parameter int BOX_STEP = DEF_BOX_STEP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   frame_evt,
    output coord_t bx,
    output coord_t by
);

    localparam coord_w_t X_LIMIT = coord_w_t'(H_DISP - BOX_SIZE);
    localparam coord_w_t Y_LIMIT = coord_w_t'(V_DISP - BOX_SIZE);
    localparam coord_w_t STEP_W  = coord_w_t'(BOX_STEP);

    axis_t x_axis_q, x_axis_d;
    axis_t y_axis_q, y_axis_d;

    // Clamp to the limit or to zero on the step that would overshoot, then turn around.
    function automatic axis_t axis_step(input axis_t cur, input coord_w_t limit);
        axis_t    nxt;
        coord_w_t pos_w;
        nxt   = cur;
        pos_w = coord_w_t'(cur.pos);
        case (cur.dir)
            DIR_INC: begin
                if (pos_w + STEP_W > limit) begin
                    nxt.pos = coord_t'(limit);
                    nxt.dir = DIR_DEC;
                end else begin
                    nxt.pos = coord_t'(pos_w + STEP_W);
                end
            end
            default: begin
                if (pos_w < STEP_W) begin
                    nxt.pos = '0;
                    nxt.dir = DIR_INC;
                end else begin
                    nxt.pos = coord_t'(pos_w - STEP_W);
                end
            end
        endcase
        return nxt;
    endfunction

    always_comb begin
        x_axis_d = x_axis_q;
        y_axis_d = y_axis_q;
        if (frame_evt) begin
            x_axis_d = axis_step(x_axis_q, X_LIMIT);
            y_axis_d = axis_step(y_axis_q, Y_LIMIT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_axis_q <= '{dir: DIR_INC, pos: '0};
            y_axis_q <= '{dir: DIR_INC, pos: '0};
        end else begin
            x_axis_q <= x_axis_d;
            y_axis_q <= y_axis_d;
        end
    end

    assign bx = x_axis_q.pos;
    assign by = y_axis_q.pos;

endmodule

// File: rtl/vga_pixel_gen.sv
// Pixel source behind the VGA timing generator: a two-stage pipeline producing RGB
// for the DAC, with sync and blank delayed by the same two clocks.
module vga_pixel_gen
    import vga_pkg::*;
#(
    parameter int   H_DISP    = DEF_H_DISP,
    parameter int   V_DISP    = DEF_V_DISP,
    parameter int   BOX_SIZE  = DEF_BOX_SIZE,
    parameter int   BOX_STEP  = DEF_BOX_STEP,
    parameter logic SYNC_ACT  = DEF_SYNC_ACT,
    parameter int   CHK_SHIFT = DEF_CHK_SHIFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_n_in,
    input  logic        disp_enable,
    input  logic [31:0] xpix,
    input  logic [31:0] ypix,
    input  logic [1:0]  mode,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int       BAR_W      = H_DISP / 8;
    localparam coord_w_t BOX_SIZE_W = coord_w_t'(BOX_SIZE);

    coord_t x_q, x_d, y_q, y_d;
    logic   de_q, de_d;
    logic   hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, bl_s1_q, bl_s1_d;
    logic   hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
    rgb_t   rgb_q, rgb_d;
    mode_e  mode_q, mode_d;

    logic     frame_evt;
    coord_t   bx, by;
    logic [2:0] bar_idx;
    logic     chk_bit;
    logic     box_hit;
    coord_w_t dx, dy;

    logic unused_hi;
    assign unused_hi = ^{xpix[31:COORD_W], ypix[31:COORD_W]};

    // The registered vsync restarts inactive after reset, so a held sync yields one event.
    assign frame_evt = (vsync_in == SYNC_ACT) && (vs_s1_q != SYNC_ACT);

    vga_box_motion #(
        .H_DISP   (H_DISP),
        .V_DISP   (V_DISP),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box_motion (
        .clk       (clk),
        .rst       (rst),
        .frame_evt (frame_evt),
        .bx        (bx),
        .by        (by)
    );

    always_comb begin
        x_d       = xpix[COORD_W-1:0];
        y_d       = ypix[COORD_W-1:0];
        de_d      = disp_enable;
        hs_s1_d   = hsync_in;
        vs_s1_d   = vsync_in;
        bl_s1_d   = blank_n_in;
        hsync_d   = hs_s1_q;
        vsync_d   = vs_s1_q;
        blank_n_d = bl_s1_q;
        mode_d    = frame_evt ? mode_e'(mode) : mode_q;
    end

    // Bar index by threshold comparison; anything past the last bar stays at 7.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (coord_w_t'(x_q) >= coord_w_t'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
        chk_bit = x_q[CHK_SHIFT] ^ y_q[CHK_SHIFT];
        dx      = coord_w_t'(x_q) - coord_w_t'(bx);
        dy      = coord_w_t'(y_q) - coord_w_t'(by);
        box_hit = (x_q >= bx) && (y_q >= by) && (dx < BOX_SIZE_W) && (dy < BOX_SIZE_W);
    end

    always_comb begin
        rgb_d = BLACK;
        if (de_q) begin
            case (mode_q)
                MODE_BARS:  rgb_d = bar_colour(bar_idx);
                MODE_CHECK: rgb_d = chk_bit ? WHITE : BLACK;
                MODE_BOX:   rgb_d = box_hit ? RED : BLUE;
                default:    rgb_d = GREY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            de_q      <= 1'b0;
            hs_s1_q   <= ~SYNC_ACT;
            vs_s1_q   <= ~SYNC_ACT;
            bl_s1_q   <= 1'b0;
            hsync_q   <= ~SYNC_ACT;
            vsync_q   <= ~SYNC_ACT;
            blank_n_q <= 1'b0;
            rgb_q     <= BLACK;
            mode_q    <= MODE_BARS;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            de_q      <= de_d;
            hs_s1_q   <= hs_s1_d;
            vs_s1_q   <= vs_s1_d;
            bl_s1_q   <= bl_s1_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
            mode_q    <= mode_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign blank_n = blank_n_q;
    assign r       = rgb_q[23:16];
    assign g       = rgb_q[15:8];
    assign b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Testbench for vga_pixel_gen: directed pixels and frames, a per-cycle comparison
// against a behavioural pattern model, and literal checks at the pattern boundaries.
module tb_vga_pixel_gen;

    localparam int LIM_X = 1280 - 64;
    localparam int LIM_Y = 1024 - 64;
    localparam logic [26:0] RESET_OUT = {1'b1, 1'b1, 1'b0, 24'h000000};
    localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic        de;
        logic [31:0] x;
        logic [31:0] y;
    } pix_in_t;

    localparam pix_in_t IDLE_IN = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, de: 1'b0, x: 32'd0, y: 32'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync_in, vsync_in, blank_n_in, disp_enable;
    logic [31:0] xpix, ypix;
    logic [1:0]  mode;
    logic        hsync, vsync, blank_n;
    logic [7:0]  r, g, b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vga_pixel_gen dut (
        .clk         (clk),
        .rst         (rst),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blank_n_in  (blank_n_in),
        .disp_enable (disp_enable),
        .xpix        (xpix),
        .ypix        (ypix),
        .mode        (mode),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .r           (r),
        .g           (g),
        .b           (b)
    );

    // Triangle wave with a one-frame dwell at each end.
    function automatic int box_pos(input int n, input int lim);
        int m, t;
        m = lim / 4;
        t = n % (2 * (m + 1));
        return (t <= m) ? 4 * t : 4 * (2 * m + 1 - t);
    endfunction

    function automatic logic [23:0] model_rgb(input pix_in_t p, input logic [1:0] md, input int n);
        int x, y, bx, by, idx;
        x = int'(p.x[10:0]);
        y = int'(p.y[10:0]);
        if (!p.de) return 24'h000000;
        case (md)
            2'd0: begin
                idx = x / 160;
                if (idx > 7) idx = 7;
                return BAR_RGB[idx];
            end
            2'd1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2'd2: begin
                bx = box_pos(n, LIM_X);
                by = box_pos(n, LIM_Y);
                return (x >= bx && x < bx + 64 && y >= by && y < by + 64) ? 24'hFF0000 : 24'h0000FF;
            end
            default: return 24'h808080;
        endcase
    endfunction

    pix_in_t     prev_in;
    logic [26:0] exp_out;
    int          frames;
    logic [1:0]  model_mode;
    logic        prev_vs_act;

    always @(posedge clk) begin
        if (rst) begin
            prev_in     <= IDLE_IN;
            exp_out     <= RESET_OUT;
            frames      <= 0;
            model_mode  <= 2'd0;
            prev_vs_act <= 1'b0;
        end else begin
            exp_out <= {prev_in.hs, prev_in.vs, prev_in.bl, model_rgb(prev_in, model_mode, frames)};
            if (vsync_in == 1'b0 && !prev_vs_act) begin
                frames     <= frames + 1;
                model_mode <= mode;
            end
            prev_vs_act <= (vsync_in == 1'b0);
            prev_in     <= '{hs: hsync_in, vs: vsync_in, bl: blank_n_in, de: disp_enable, x: xpix, y: ypix};
        end
    end

    always @(negedge clk) begin
        logic [26:0] actual, want;
        #1;
        actual = {hsync, vsync, blank_n, r, g, b};
        want   = rst ? RESET_OUT : exp_out;
        tests_run++;
        if (actual !== want) begin
            tests_failed++;
            $display("[TB] FAIL pipeline_model at %0t: got %h want %h", $time, actual, want);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic hs, input logic vs, input logic bl, input logic de,
                                 input int x, input int y);
        @(negedge clk);
        hsync_in    = hs;
        vsync_in    = vs;
        blank_n_in  = bl;
        disp_enable = de;
        xpix        = 32'(x);
        ypix        = 32'(y);
    endtask

    task automatic checkPixel(input string name, input int x, input int y, input logic de,
                              input logic [23:0] want);
        applyStimulus(1'b1, 1'b1, de, de, x, y);
        repeat (2) @(posedge clk);
        #1;
        checkOutput(name, {8'h00, r, g, b}, {8'h00, want});
    endtask

    task automatic doFrames(input int count);
        for (int f = 0; f < count; f++) begin
            repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
            repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        mode = 2'd0;
        hsync_in = 1'b1; vsync_in = 1'b1; blank_n_in = 1'b0; disp_enable = 1'b0;
        xpix = '0; ypix = '0;

        checkOutput("model_box_5",   32'(box_pos(5, LIM_X)),   32'd20);
        checkOutput("model_box_305", 32'(box_pos(305, LIM_X)), 32'd1216);
        checkOutput("model_box_306", 32'(box_pos(306, LIM_X)), 32'd1212);
        checkOutput("model_by_241",  32'(box_pos(241, LIM_Y)), 32'd960);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", {5'd0, hsync, vsync, blank_n, r, g, b}, {5'd0, RESET_OUT});
        @(negedge clk);
        rst = 1'b0;
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

        checkPixel("bars_x0",    0,    10, 1'b1, 24'hFFFFFF);
        checkPixel("bars_x159",  159,  10, 1'b1, 24'hFFFFFF);
        checkPixel("bars_x160",  160,  10, 1'b1, 24'hFFFF00);
        checkPixel("bars_x800",  800,  10, 1'b1, 24'hFF0000);
        checkPixel("bars_x1279", 1279, 10, 1'b1, 24'h000000);
        checkPixel("bars_x2000", 2000, 10, 1'b1, 24'h000000);
        checkPixel("bars_de0",   160,  10, 1'b0, 24'h000000);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
        @(posedge clk); #1;
        checkOutput("hsync_lat1", {31'd0, hsync}, 32'd1);
        @(posedge clk); #1;
        checkOutput("hsync_lat2", {31'd0, hsync}, 32'd0);

        mode = 2'd1;
        doFrames(1);
        checkPixel("check_0_0",   0,  0,  1'b1, 24'h000000);
        checkPixel("check_32_0",  32, 0,  1'b1, 24'hFFFFFF);
        checkPixel("check_32_32", 32, 32, 1'b1, 24'h000000);
        checkPixel("check_de0",   32, 0,  1'b0, 24'h000000);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst  = 1'b1;
        mode = 2'd2;
        #1;
        checkOutput("reset_immediate", {5'd0, hsync, vsync, blank_n, r, g, b}, {5'd0, RESET_OUT});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("resume_edge1", {29'd0, hsync, vsync, blank_n}, {29'd0, 3'b110});
        @(posedge clk); #1;
        checkOutput("resume_edge2", {29'd0, hsync, vsync, blank_n}, {29'd0, 3'b000});
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

        doFrames(4);
        checkPixel("box5_20_20", 20, 20, 1'b1, 24'hFF0000);
        checkPixel("box5_19_20", 19, 20, 1'b1, 24'h0000FF);
        checkPixel("box5_84_20", 84, 20, 1'b1, 24'h0000FF);
        checkPixel("box5_83_83", 83, 83, 1'b1, 24'hFF0000);
        checkPixel("box5_20_84", 20, 84, 1'b1, 24'h0000FF);

        doFrames(235);
        checkPixel("box240_960",  960,  960,  1'b1, 24'hFF0000);
        checkPixel("box240_959",  959,  960,  1'b1, 24'h0000FF);
        checkPixel("box240_1023", 1023, 1023, 1'b1, 24'hFF0000);
        doFrames(1);
        checkPixel("box241_964", 964, 960, 1'b1, 24'hFF0000);
        checkPixel("box241_963", 963, 960, 1'b1, 24'h0000FF);

        doFrames(64);
        checkPixel("box305_1216", 1216, 704, 1'b1, 24'hFF0000);
        checkPixel("box305_1215", 1215, 704, 1'b1, 24'h0000FF);
        checkPixel("box305_1279", 1279, 767, 1'b1, 24'hFF0000);
        doFrames(1);
        checkPixel("box306_1212", 1212, 700, 1'b1, 24'hFF0000);
        checkPixel("box306_1211", 1211, 700, 1'b1, 24'h0000FF);
        checkPixel("box306_1276", 1276, 700, 1'b1, 24'h0000FF);

        mode = 2'd0;
        doFrames(1);
        checkPixel("mode_bars", 0, 0, 1'b1, 24'hFFFFFF);
        @(negedge clk);
        mode = 2'd3;
        checkPixel("mode_mid_frame", 0, 0, 1'b1, 24'hFFFFFF);
        doFrames(1);
        checkPixel("grey_0_0",     0,   0,   1'b1, 24'h808080);
        checkPixel("grey_700_900", 700, 900, 1'b1, 24'h808080);
        checkPixel("grey_de0",     700, 900, 1'b0, 24'h000000);

        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
